// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and parity helper shared by the UART TX and RX controllers.
// Contents: tx_state_t (FSM encoding), data_len_t (0=5 .. 3=8 data bits),
//           UART_IDLE_LVL, DATA_LEN_BASE, calc_parity().
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef logic [1:0] data_len_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   DATA_LEN_BASE = 5;

    // Bits above the configured data length are masked out before the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input data_len_t len, input logic even);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - len);
        return ^(data & mask) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: configuration, TX FIFO and serial-line bundle of the UART transmit controller.
// master: register block / FIFO side (drives cfg_*, fifo_empty, fifo_rdata).
// slave : uart_tx_ctrl (drives fifo_rd, uart_tx, tx_busy, tx_done).
interface uart_tx_ctrl_if #(parameter int DIV_W = 16) ();
    import uart_pkg::*;

    logic             cfg_tx_en;
    logic [DIV_W-1:0] cfg_div;
    data_len_t        cfg_data_len;
    logic             cfg_parity_en;
    logic             cfg_parity_even;
    logic             cfg_stop2;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             fifo_rd;
    logic             uart_tx;
    logic             tx_busy;
    logic             tx_done;

    modport master (
        output cfg_tx_en, cfg_div, cfg_data_len, cfg_parity_en, cfg_parity_even, cfg_stop2,
        output fifo_empty, fifo_rdata,
        input  fifo_rd, uart_tx, tx_busy, tx_done
    );

    modport slave (
        input  cfg_tx_en, cfg_div, cfg_data_len, cfg_parity_en, cfg_parity_even, cfg_stop2,
        input  fifo_empty, fifo_rdata,
        output fifo_rd, uart_tx, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; one bit lasts OSR*(i_div+1) pclk cycles.
// Ports: pclk, preset_n (async active-low), i_clear (hold counter at 0),
//        i_div (baud divisor), o_bit_end (high in the last cycle of each bit).
module uart_baud_gen #(
    parameter int OSR   = 16,
    parameter int DIV_W = 16
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_bit_end
);
    localparam int CW = DIV_W + $clog2(OSR);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_limit;

    // At the largest divisor the product wraps to 0 and the -1 brings it back to all-ones.
    assign w_limit   = CW'(OSR) * (CW'(i_div) + CW'(1)) - CW'(1);
    assign o_bit_end = !i_clear && (r_cnt == w_limit);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) r_cnt <= '0;
        else           r_cnt <= (i_clear || o_bit_end) ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller; pops bytes from the TX FIFO and serialises start/data/parity/stop.
// Ports: pclk, preset_n (async active-low), bus (uart_tx_ctrl_if.slave: cfg_*, fifo_*, uart_tx,
//        tx_busy, tx_done).
module uart_tx_ctrl #(
    parameter int OSR   = 16,
    parameter int DIV_W = 16
) (
    input logic           pclk,
    input logic           preset_n,
    uart_tx_ctrl_if.slave bus
);
    import uart_pkg::*;

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);

    logic [2:0]       r_state;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [2:0]       r_last;
    logic             r_par_en;
    logic             r_par;
    logic             r_stop2;
    logic [DIV_W-1:0] r_div;
    logic             r_tx;

    logic [2:0]       w_nxt_state;
    logic [2:0]       w_nxt_idx;
    logic [7:0]       w_nxt_shift;
    logic             w_nxt_tx;
    logic             w_bit_end;
    logic             w_done;
    logic             w_pop;

    uart_baud_gen #(.OSR(OSR), .DIV_W(DIV_W)) u_baud (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .i_clear   (r_state == S_IDLE),
        .i_div     (r_div),
        .o_bit_end (w_bit_end)
    );

    // r_idx counts stop bits in STOP, so the frame ends at index r_stop2.
    assign w_done = (r_state == S_STOP) && w_bit_end && (r_idx == {2'b00, r_stop2});
    // preset_n gating keeps the pop strobe quiet while reset is held.
    assign w_pop  = preset_n && bus.cfg_tx_en && !bus.fifo_empty && (r_state == S_IDLE || w_done);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_shift = r_shift;
        if (w_pop) begin
            w_nxt_state = S_START;
            w_nxt_shift = bus.fifo_rdata;
        end else if (w_bit_end) begin
            case (r_state)
                S_START: begin
                    w_nxt_state = S_DATA;
                    w_nxt_idx   = '0;
                end
                S_DATA: begin
                    w_nxt_shift = r_shift >> 1;
                    w_nxt_idx   = (r_idx == r_last) ? '0 : r_idx + 3'd1;
                    w_nxt_state = (r_idx != r_last) ? S_DATA : r_par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: w_nxt_state = S_STOP;
                S_STOP: begin
                    w_nxt_idx   = r_idx + 3'd1;
                    w_nxt_state = w_done ? S_IDLE : S_STOP;
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    // The line is registered from the next state so it changes exactly on bit boundaries.
    assign w_nxt_tx = (w_nxt_state == S_START)  ? 1'b0 :
                      (w_nxt_state == S_DATA)   ? w_nxt_shift[0] :
                      (w_nxt_state == S_PARITY) ? r_par : UART_IDLE_LVL;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_shift  <= '0;
            r_last   <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_stop2  <= 1'b0;
            r_div    <= '0;
            r_tx     <= UART_IDLE_LVL;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_shift <= w_nxt_shift;
            r_tx    <= w_nxt_tx;
            if (w_pop) begin
                r_last   <= 3'(DATA_LEN_BASE - 1) + {1'b0, bus.cfg_data_len};
                r_par_en <= bus.cfg_parity_en;
                r_par    <= calc_parity(bus.fifo_rdata, bus.cfg_data_len, bus.cfg_parity_even);
                r_stop2  <= bus.cfg_stop2;
                r_div    <= bus.cfg_div;
            end
        end
    end

    assign bus.fifo_rd = w_pop;
    assign bus.uart_tx = r_tx;
    assign bus.tx_busy = (r_state != S_IDLE);
    assign bus.tx_done = w_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with hand-computed line patterns.
module tb_uart_tx_ctrl;
    localparam int OSR   = 16;
    localparam int DIV_W = 16;

    logic pclk     = 1'b0;
    logic preset_n = 1'b0;

    uart_tx_ctrl_if #(.DIV_W(DIV_W)) bus ();

    uart_tx_ctrl #(.OSR(OSR), .DIV_W(DIV_W)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:15];
    logic [3:0] rp = '0;
    logic [3:0] wp = '0;
    int rd_cnt   = 0;
    int rd_empty = 0;

    assign bus.fifo_empty = (rp == wp);
    assign bus.fifo_rdata = mem[rp];

    always @(posedge pclk) begin
        if (bus.fifo_rd) begin
            rp       <= rp + 4'd1;
            rd_cnt   <= rd_cnt + 1;
            if (rp == wp) rd_empty <= rd_empty + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 4'd1;
    endtask

    task automatic set_cfg(input int div, input logic [1:0] len, input logic pen, input logic peven, input logic s2);
        bus.cfg_div         = DIV_W'(div);
        bus.cfg_data_len    = len;
        bus.cfg_parity_en   = pen;
        bus.cfg_parity_even = peven;
        bus.cfg_stop2       = s2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle line"}, 32'(bus.uart_tx), 32'd1);
        chk({tag, " idle busy"}, 32'(bus.tx_busy), 32'd0);
        chk({tag, " idle done"}, 32'(bus.tx_done), 32'd0);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.uart_tx !== 1'b0 && n < 100);
        chk({tag, " start latency"}, 32'(n), 32'd1);
    endtask

    // Entered on cycle 0 of START; returns on the last cycle of the last stop bit.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits, input int b,
                               input logic exp_pop, input int drop_at);
        int last;
        last = nbits * b - 1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) tick();
            chk($sformatf("%s line c%0d", tag, i), 32'(bus.uart_tx), 32'(bits[i / b]));
            chk($sformatf("%s busy c%0d", tag, i), 32'(bus.tx_busy), 32'd1);
            chk($sformatf("%s done c%0d", tag, i), 32'(bus.tx_done), 32'(i == last));
            chk($sformatf("%s rd c%0d", tag, i), 32'(bus.fifo_rd), 32'((i == last) && exp_pop));
            if (i == drop_at) begin
                bus.cfg_tx_en = 1'b0;
                set_cfg(5, 2'd0, 1'b1, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.cfg_tx_en = 1'b1;
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
        push(8'h55);
        repeat (3) tick();
        chk("rst line", 32'(bus.uart_tx), 32'd1);
        chk("rst busy", 32'(bus.tx_busy), 32'd0);
        chk("rst done", 32'(bus.tx_done), 32'd0);
        chk("rst rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst no pop", 32'(rd_cnt), 32'd0);
        preset_n = 1'b1;

        // 0x55, 8N1, div 0
        wait_start("f55");
        check_frame("f55", 16'h02AA, 10, 16, 1'b0, -1);
        tick();
        chk_idle("f55");
        chk("f55 pops", 32'(rd_cnt), 32'd1);

        // 0xA3, 7 bits, even parity, 2 stop, div 2
        set_cfg(2, 2'd2, 1'b1, 1'b1, 1'b1);
        push(8'hA3);
        wait_start("a3e");
        check_frame("a3e", 16'h0746, 11, 48, 1'b0, -1);
        tick();
        chk_idle("a3e");

        // same byte, odd parity
        set_cfg(2, 2'd2, 1'b1, 1'b0, 1'b1);
        push(8'hA3);
        wait_start("a3o");
        check_frame("a3o", 16'h0646, 11, 48, 1'b0, -1);
        tick();
        chk_idle("a3o");

        // 0xFF, 5 bits, odd parity, 1 stop: upper three ones excluded from parity
        set_cfg(0, 2'd0, 1'b1, 1'b0, 1'b0);
        push(8'hFF);
        wait_start("ff5");
        check_frame("ff5", 16'h00BE, 8, 16, 1'b0, -1);
        tick();
        chk_idle("ff5");
        chk("ff5 pops", 32'(rd_cnt), 32'd4);

        // three back-to-back frames
        bus.cfg_tx_en = 1'b0;
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
        push(8'h01);
        push(8'h80);
        push(8'hC3);
        bus.cfg_tx_en = 1'b1;
        wait_start("b2b0");
        check_frame("b2b0", 16'h0202, 10, 16, 1'b1, -1);
        tick();
        check_frame("b2b1", 16'h0300, 10, 16, 1'b1, -1);
        tick();
        check_frame("b2b2", 16'h0386, 10, 16, 1'b0, -1);
        tick();
        chk_idle("b2b");
        chk("b2b pops", 32'(rd_cnt), 32'd7);

        // enable and config changed mid-DATA: frame unaffected, no further pop
        bus.cfg_tx_en = 1'b0;
        push(8'h0F);
        push(8'h5A);
        bus.cfg_tx_en = 1'b1;
        wait_start("drop");
        check_frame("drop", 16'h021E, 10, 16, 1'b0, 40);
        repeat (5) begin
            tick();
            chk_idle("drop");
        end
        chk("drop pops", 32'(rd_cnt), 32'd8);
        chk("drop fifo kept", 32'(bus.fifo_empty), 32'd0);

        // reset mid-DATA aborts the frame; a clean frame follows release
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
        bus.cfg_tx_en = 1'b1;
        wait_start("mrst");
        repeat (40) tick();
        chk("mrst busy before", 32'(bus.tx_busy), 32'd1);
        preset_n = 1'b0;
        #1;
        chk("mrst line", 32'(bus.uart_tx), 32'd1);
        chk("mrst busy", 32'(bus.tx_busy), 32'd0);
        chk("mrst rd", 32'(bus.fifo_rd), 32'd0);
        push(8'h3C);
        repeat (2) tick();
        chk("mrst held line", 32'(bus.uart_tx), 32'd1);
        preset_n = 1'b1;
        wait_start("post");
        check_frame("post", 16'h0278, 10, 16, 1'b0, -1);
        tick();
        chk_idle("post");
        chk("final pops", 32'(rd_cnt), 32'd10);
        chk("rd while empty", 32'(rd_empty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
